// File: rtl/alu_wb_buffer_pkg.sv
// Shared definitions for the ALU-to-writeback skid buffer:
// default widths and the record carried through each FIFO slot.
package alu_wb_buffer_pkg;

    localparam int DATA_WIDTH_DEFAULT     = 16;
    localparam int REG_ADDR_WIDTH_DEFAULT = 3;

    typedef struct packed {
        logic [DATA_WIDTH_DEFAULT-1:0]     result;
        logic                              zero;
        logic [REG_ADDR_WIDTH_DEFAULT-1:0] rd;
        logic                              we;
    } wb_entry;

endpackage

// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU stage, the buffer and the writeback stage.
// The master drives beats in and consumes the head; the slave is the buffer.
interface alu_wb_buffer_if
    import alu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
);

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_WIDTH-1:0]     in_result;
    logic                      in_zero;
    logic [REG_ADDR_WIDTH-1:0] in_rd;
    logic                      in_we;
    logic                      flush;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_result;
    logic                      out_zero;
    logic [REG_ADDR_WIDTH-1:0] out_rd;
    logic                      out_we;
    logic [1:0]                count;

    modport master (
        output in_valid, in_result, in_zero, in_rd, in_we, flush, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_rd, out_we, count
    );

    modport slave (
        input  in_valid, in_result, in_zero, in_rd, in_we, flush, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_rd, out_we, count
    );

endinterface

// File: rtl/alu_wb_buffer.sv
// Two-entry FIFO between the ALU and writeback. Handshake outputs depend only on
// registered state, and the head fields come from a register so they hold when empty.
module alu_wb_buffer
    import alu_wb_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
)(
    input  logic            clk,
    input  logic            rst,
    alu_wb_buffer_if.slave  bus
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]     result;
        logic                      zero;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      we;
    } entry_t;

    entry_t     r_mem [2];
    entry_t     r_out;
    logic       r_head;
    logic       r_tail;
    logic [1:0] r_count;

    entry_t     w_inEntry;
    entry_t     w_nextOut;
    logic       w_push;
    logic       w_pop;
    logic       w_nextHead;
    logic       w_nextTail;
    logic [1:0] w_nextCount;

    assign bus.in_ready   = (r_count != 2'd2);
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_result = r_out.result;
    assign bus.out_zero   = r_out.zero;
    assign bus.out_rd     = r_out.rd;
    assign bus.out_we     = r_out.we;
    assign bus.count      = r_count;

    assign w_inEntry = '{result: bus.in_result, zero: bus.in_zero,
                         rd: bus.in_rd, we: bus.in_we};
    assign w_push    = bus.in_valid && bus.in_ready;
    assign w_pop     = bus.out_valid && bus.out_ready;

    // The next head may be the beat being written this cycle (empty buffer, or
    // push+pop at occupancy one), so bypass the write into the output register.
    always_comb begin
        w_nextHead  = r_head ^ w_pop;
        w_nextTail  = r_tail ^ w_push;
        w_nextCount = r_count;
        case ({w_push, w_pop})
            2'b10:   w_nextCount = r_count + 2'd1;
            2'b01:   w_nextCount = r_count - 2'd1;
            default: w_nextCount = r_count;
        endcase
        w_nextOut = r_mem[w_nextHead];
        if (w_push && (w_nextHead == r_tail)) begin
            w_nextOut = w_inEntry;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
            r_out   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= w_inEntry;
            end
            r_head  <= w_nextHead;
            r_tail  <= w_nextTail;
            r_count <= w_nextCount;
            if (w_nextCount != 2'd0) begin
                r_out <= w_nextOut;
            end
        end
    end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Randomised and directed bench for alu_wb_buffer, checked every cycle against a
// queue-based model of the buffer contents plus a few literal expectations.
module tb_alu_wb_buffer;
    import alu_wb_buffer_pkg::*;

    logic clk;
    logic rst;

    alu_wb_buffer_if bus ();

    alu_wb_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      total = 0;
    int      bad   = 0;
    wb_entry modelQ[$];
    wb_entry lastOut;
    bit      modelKnown = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Compare the DUT against the model, then advance the model by one edge.
    task automatic applyStimulus(input bit iRst, input bit iFlush, input bit iValid,
                                 input logic [15:0] iResult, input bit iZero,
                                 input logic [2:0] iRd, input bit iWe,
                                 input bit iOutReady);
        wb_entry exp;
        wb_entry beat;
        bit      doPush;
        bit      doPop;
        rst           = iRst;
        bus.flush     = iFlush;
        bus.in_valid  = iValid;
        bus.in_result = iResult;
        bus.in_zero   = iZero;
        bus.in_rd     = iRd;
        bus.in_we     = iWe;
        bus.out_ready = iOutReady;
        @(negedge clk);
        if (modelKnown) begin
            exp = (modelQ.size() != 0) ? modelQ[0] : lastOut;
            checkOutput("count",      32'(bus.count),      32'(modelQ.size()));
            checkOutput("countMax",   32'(bus.count <= 2'd2), 32'd1);
            checkOutput("in_ready",   32'(bus.in_ready),   32'(modelQ.size() != 2));
            checkOutput("out_valid",  32'(bus.out_valid),  32'(modelQ.size() != 0));
            checkOutput("out_result", 32'(bus.out_result), 32'(exp.result));
            checkOutput("out_zero",   32'(bus.out_zero),   32'(exp.zero));
            checkOutput("out_rd",     32'(bus.out_rd),     32'(exp.rd));
            checkOutput("out_we",     32'(bus.out_we),     32'(exp.we));
        end
        if (iRst) begin
            modelQ.delete();
            lastOut    = '0;
            modelKnown = 1'b1;
        end else if (iFlush) begin
            modelQ.delete();
        end else begin
            doPop  = (modelQ.size() != 0) && iOutReady;
            doPush = iValid && (modelQ.size() != 2);
            if (doPop) void'(modelQ.pop_front());
            if (doPush) begin
                beat = '{result: iResult, zero: iZero, rd: iRd, we: iWe};
                modelQ.push_back(beat);
            end
            if (modelQ.size() != 0) lastOut = modelQ[0];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit iOutReady);
        applyStimulus(0, 0, 0, 16'h0, 0, 3'd0, 0, iOutReady);
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.in_zero   = 1'b0;
        bus.in_rd     = '0;
        bus.in_we     = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(1, 0, 0, 16'h0, 0, 3'd0, 0, 0);
        checkOutput("rst_count",  32'(bus.count),      32'd0);
        checkOutput("rst_ready",  32'(bus.in_ready),   32'd1);
        checkOutput("rst_valid",  32'(bus.out_valid),  32'd0);
        checkOutput("rst_result", 32'(bus.out_result), 32'h0);

        applyStimulus(0, 0, 1, 16'h1234, 0, 3'd3, 1, 0);
        checkOutput("first_valid",  32'(bus.out_valid),  32'd1);
        checkOutput("first_result", 32'(bus.out_result), 32'h1234);
        checkOutput("first_rd",     32'(bus.out_rd),     32'd3);
        checkOutput("first_count",  32'(bus.count),      32'd1);
        idle(1);

        applyStimulus(0, 0, 1, 16'h0001, 1, 3'd1, 0, 0);
        applyStimulus(0, 0, 1, 16'h0002, 0, 3'd2, 1, 0);
        checkOutput("full_count",  32'(bus.count),      32'd2);
        checkOutput("full_ready",  32'(bus.in_ready),   32'd0);
        checkOutput("full_head",   32'(bus.out_result), 32'h0001);
        idle(1);
        checkOutput("drain1_result", 32'(bus.out_result), 32'h0002);
        checkOutput("drain1_ready",  32'(bus.in_ready),   32'd1);
        idle(1);
        checkOutput("drain2_count",  32'(bus.count),    32'd0);
        checkOutput("drain2_ready",  32'(bus.in_ready), 32'd1);

        applyStimulus(0, 0, 1, 16'h00AA, 0, 3'd4, 1, 0);
        applyStimulus(0, 0, 1, 16'h00BB, 1, 3'd5, 1, 1);
        checkOutput("swap_count",  32'(bus.count),      32'd1);
        checkOutput("swap_result", 32'(bus.out_result), 32'h00BB);

        applyStimulus(0, 0, 1, 16'h00CC, 0, 3'd6, 0, 0);
        applyStimulus(0, 1, 1, 16'h00DD, 0, 3'd7, 1, 0);
        checkOutput("flush_count", 32'(bus.count),     32'd0);
        checkOutput("flush_valid", 32'(bus.out_valid), 32'd0);
        idle(0);
        checkOutput("flush_dropped", 32'(bus.count), 32'd0);

        applyStimulus(0, 0, 1, 16'h0011, 0, 3'd1, 1, 0);
        applyStimulus(1, 0, 1, 16'h00EE, 1, 3'd2, 1, 1);
        checkOutput("rstpush_count",  32'(bus.count),      32'd0);
        checkOutput("rstpush_valid",  32'(bus.out_valid),  32'd0);
        checkOutput("rstpush_result", 32'(bus.out_result), 32'h0000);

        for (int i = 0; i < 1000; i++) begin
            applyStimulus(0, 0, 1'($urandom_range(0, 1)), 16'($urandom),
                          1'($urandom), 3'($urandom), 1'($urandom),
                          1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0),
                          1'($urandom), 16'($urandom), 1'($urandom), 3'($urandom),
                          1'($urandom), 1'($urandom));
        end

        for (int i = 0; i < 3; i++) idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, which sets the ALU result width.
REQ-002 The module SHALL have parameter REG_ADDR_WIDTH, default 3, which sets the destination register index width.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1 bit: the ALU-stage beat is valid.
REQ-007 Port in_ready, output, 1 bit: the buffer accepts a beat this cycle.
REQ-008 Port in_result, input, DATA_WIDTH bits: ALU result.
REQ-009 Port in_zero, input, 1 bit: ALU zero flag.
REQ-010 Port in_rd, input, REG_ADDR_WIDTH bits: destination register index.
REQ-011 Port in_we, input, 1 bit: register write enable.
REQ-012 Port flush, input, 1 bit: discard all buffered beats.
REQ-013 Port out_valid, output, 1 bit: the head beat is valid for writeback.
REQ-014 Port out_ready, input, 1 bit: writeback consumes the head beat.
REQ-015 Ports out_result (DATA_WIDTH bits), out_zero (1 bit), out_rd (REG_ADDR_WIDTH bits) and out_we (1 bit), all outputs: head-entry fields.
REQ-016 Port count, output, 2 bits: occupancy, range 0..2.

Function
REQ-017 The storage SHALL be a 2-entry FIFO of {result, zero, rd, we}, using a head pointer, a tail pointer and a count.
REQ-018 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal (count != 2) and SHALL be a function of registered state only, with no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); the out_* fields SHALL always present the head entry.
REQ-021 Latency: a beat pushed in cycle N SHALL appear on out_* with out_valid=1 in cycle N+1 when the buffer was empty; there SHALL be no combinational input-to-output path.
REQ-022 Count update SHALL be: push only -> +1; pop only -> -1; push and pop together -> unchanged.
REQ-023 count==1 with simultaneous push and pop: the old head SHALL retire and the new beat SHALL become the head in the next cycle.
REQ-024 count==2: in_ready SHALL be 0, and a pop SHALL raise in_ready in the next cycle.
REQ-025 Pointers SHALL wrap modulo 2; entries SHALL retire in strict FIFO order.
REQ-026 Data fields of a held (non-popped) head SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 Flush SHALL take priority: count, head and tail SHALL return to 0 at the next edge, and any same-cycle push or pop SHALL be ignored.
REQ-028 Entries SHALL be stored regardless of the in_we value; in_we is carried through only.
REQ-029 When the buffer is empty, out_* data SHALL hold its last value; consumers SHALL qualify it with out_valid.

Reset
REQ-030 On rst=1 at a clock edge: count=0, pointers=0, out_valid=0, in_ready=1, and all entry storage and out_* data SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries, and rst SHALL take priority over flush, push and pop.
REQ-032 Reset SHALL take effect only on a clock edge, with no asynchronous behaviour.

Structure
REQ-033 A shared package SHALL hold DATA_WIDTH_DEFAULT=16, REG_ADDR_WIDTH_DEFAULT=3 and the wb_entry record type {result, zero, rd, we}.
REQ-034 The block SHALL have no sub-module; the 2-entry register array and pointer logic SHALL be flat in alu_wb_buffer.

Verification
REQ-035 Reset then push {result=16'h1234, zero=0, rd=3, we=1} with out_ready=0 -> next cycle out_valid=1, out_result=16'h1234, out_rd=3, count=1.
REQ-036 Push 16'h0001 and 16'h0002 with out_ready=0 -> count=2, in_ready=0; then assert out_ready for 2 cycles -> outputs 16'h0001 then 16'h0002, after which count=0 and in_ready=1.
REQ-037 count=1 holding 16'h00AA with simultaneous push 16'h00BB and pop -> next cycle count=1 and out_result=16'h00BB.
REQ-038 count=2 and flush=1 with in_valid=1 -> next cycle count=0 and out_valid=0, and the pushed beat is not stored.
REQ-039 Push a beat and assert rst in the same cycle -> next cycle count=0, out_valid=0, out_result=16'h0000.
REQ-040 Random in_valid/out_ready over 1000 cycles -> output sequence equals the accepted-input sequence, count never exceeds 2, and no accepted beat is lost.
